// File: rtl/gbsha_ttfir_host.sv
// Host driver for the TinyTapeout FIR pins: IDLE -> FRST (fir_reset) -> CFG -> LOAD (coefs) -> RUN.
// In RUN it issues samples and rebuilds signed results from the FIR's MSB (and optional LSB) bytes.
module gbsha_ttfir_host #(
    parameter int N_TAPS     = 4,
    parameter int BW_in      = 6,
    parameter int BW_sum     = 13,
    parameter int BW_out     = 8,
    parameter int RST_CYCLES = 2,
    parameter int AW         = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [BW_in-1:0]  coef_data,
    input  logic                     lsb_mode,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [BW_in-1:0]  in_data,
    output logic                     in_ready,
    output logic                     result_valid,
    output logic signed [BW_sum-1:0] result_data,
    output logic                     running,
    output logic [7:0]               fir_io_in,
    input  logic [7:0]               fir_io_out
);
    localparam int LOW  = BW_sum - BW_out;
    localparam int CMAX = (RST_CYCLES > N_TAPS) ? RST_CYCLES : N_TAPS;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, FRST, CFG, LOAD, RUN} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    lsb;
    logic                    fir_reset;
    logic [BW_in-1:0]        fir_x;
    logic [2:0]              tag;
    logic [BW_out-1:0]       m_hold;
    logic signed [BW_in-1:0] coef_file [N_TAPS];
    logic signed [BW_in-1:0] coef_act  [N_TAPS];
    logic [AW-1:0]           load_idx;
    logic                    issue;

    assign fir_io_in = {fir_x, fir_reset, 1'b0};
    assign running   = (state == RUN);
    assign load_idx  = AW'(cnt - CW'(1));
    assign issue     = in_ready && in_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_TAPS; i++) coef_file[i] <= '0;
        end else if (coef_we) begin
            coef_file[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            lsb          <= 1'b0;
            fir_reset    <= 1'b1;
            fir_x        <= '0;
            in_ready     <= 1'b0;
            result_valid <= 1'b0;
            result_data  <= '0;
            tag          <= '0;
            m_hold       <= '0;
            for (int i = 0; i < N_TAPS; i++) coef_act[i] <= '0;
        end else begin
            result_valid <= 1'b0;
            // A restart from RUN clears the tags so in-flight samples never report.
            if (start && (state == IDLE || state == RUN)) begin
                state     <= FRST;
                cnt       <= CW'(RST_CYCLES - 1);
                lsb       <= lsb_mode;
                fir_reset <= 1'b1;
                fir_x     <= '0;
                in_ready  <= 1'b0;
                tag       <= '0;
                coef_act  <= coef_file;
            end else begin
                case (state)
                    IDLE: begin
                        fir_reset <= 1'b1;
                        fir_x     <= '0;
                    end
                    FRST: begin
                        if (cnt == '0) begin
                            state     <= CFG;
                            fir_reset <= 1'b0;
                            fir_x     <= {{(BW_in-1){1'b0}}, lsb};
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    CFG: begin
                        state <= LOAD;
                        cnt   <= CW'(N_TAPS - 1);
                        fir_x <= coef_act[N_TAPS-1];
                    end
                    LOAD: begin
                        if (cnt == '0) begin
                            state    <= RUN;
                            fir_x    <= '0;
                            in_ready <= 1'b1;
                            tag      <= '0;
                        end else begin
                            cnt   <= cnt - CW'(1);
                            fir_x <= coef_act[load_idx];
                        end
                    end
                    RUN: begin
                        in_ready <= lsb ? ~in_ready : 1'b1;
                        fir_x    <= issue ? in_data : '0;
                        tag      <= {tag[1:0], issue};
                        if (!lsb) begin
                            if (tag[1]) begin
                                result_valid <= 1'b1;
                                result_data  <= {fir_io_out, {LOW{1'b0}}};
                            end
                        end else begin
                            if (tag[1]) m_hold <= fir_io_out;
                            if (tag[2]) begin
                                result_valid <= 1'b1;
                                result_data  <= {m_hold, fir_io_out[LOW-1:0]};
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gbsha_ttfir_host.sv
// Directed bench for gbsha_ttfir_host with a behavioural model of the TinyTapeout FIR on the pins.
module tb_gbsha_ttfir_host;
    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              coef_we = 1'b0;
    logic [1:0]        coef_addr = '0;
    logic signed [5:0] coef_data = '0;
    logic              lsb_mode = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [5:0] in_data = '0;
    logic              in_ready, result_valid, running;
    logic signed [12:0] result_data;
    logic [7:0]        fir_io_in, fir_io_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int st_cyc = 0;
    logic [12:0]       res_q[$];
    int                res_cyc[$];
    logic signed [5:0] smp_d[8];
    bit                smp_v[8];
    logic [12:0]       exp_r[8];

    gbsha_ttfir_host dut (
        .clk(clk), .reset_n(reset_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .lsb_mode(lsb_mode), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .result_valid(result_valid),
        .result_data(result_data), .running(running), .fir_io_in(fir_io_in),
        .fir_io_out(fir_io_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIR pin model: fir_reset, config word, N coefficient words, then streaming.
    logic signed [5:0] f_c[4];
    logic signed [5:0] f_d[4];
    int   f_st = 0;
    int   f_k = 0;
    bit   f_lsb = 1'b0;
    bit   f_ph = 1'b0;
    logic [7:0] f_lo = '0;
    always @(posedge clk) begin : fir_model
        logic signed [5:0] x;
        int s;
        logic [31:0] sv;
        x = fir_io_in[7:2];
        if (fir_io_in[1]) begin
            f_st = 1;
            for (int i = 0; i < 4; i++) f_d[i] = '0;
            fir_io_out <= '0;
        end else if (f_st == 1) begin
            f_lsb = x[0];
            f_st = 2;
            f_k = 0;
        end else if (f_st == 2) begin
            for (int i = 3; i > 0; i--) f_c[i] = f_c[i-1];
            f_c[0] = x;
            f_k++;
            if (f_k == 4) begin
                f_st = 3;
                f_ph = 1'b0;
            end
        end else if (f_st == 3) begin
            if (!f_lsb || f_ph) begin
                for (int i = 3; i > 0; i--) f_d[i] = f_d[i-1];
                f_d[0] = x;
                s = 0;
                for (int j = 0; j < 4; j++) s += f_c[j] * f_d[j];
                sv = s;
                fir_io_out <= sv[12:5];
                f_lo = sv[7:0];
            end else begin
                fir_io_out <= f_lo;
            end
            f_ph = !f_ph;
        end
    end

    always @(negedge clk) begin
        if (result_valid) begin
            res_q.push_back(result_data);
            res_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_coefs(input int c0, input int c1, input int c2, input int c3);
        int c[4];
        c = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            coef_we = 1'b1;
            coef_addr = 2'(i);
            coef_data = 6'(c[i]);
        end
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic wait_run();
        int g = 0;
        while (!running && g < 30) begin
            @(negedge clk);
            g++;
        end
        check("run_reached", running, 1);
    endtask

    task automatic do_start(input bit lsb);
        @(negedge clk);
        lsb_mode = lsb;
        start = 1'b1;
        st_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_run();
    endtask

    task automatic send(input int n);
        int i = 0;
        int g = 0;
        while (i < n && g < 100) begin
            if (in_ready) begin
                in_valid = smp_v[i];
                in_data = smp_d[i];
                if (i == 0) acc_cyc = cyc;
                i++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            g++;
        end
        in_valid = 1'b0;
        check("send_done", i, n);
    endtask

    task automatic run_case(input string tag, input int ns, input int ne, input int lat);
        res_q.delete();
        res_cyc.delete();
        send(ns);
        repeat (10) @(negedge clk);
        check({tag, "_count"}, res_q.size(), ne);
        for (int i = 0; i < ne && i < res_q.size(); i++)
            check($sformatf("%s_r%0d", tag, i), res_q[i], exp_r[i]);
        if (lat > 0 && res_cyc.size() > 0)
            check({tag, "_lat"}, res_cyc[0] - acc_cyc, lat);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        smp_v = '{default: 1'b1};
        repeat (2) @(negedge clk);
        check("rst_io", fir_io_in, 8'h02);
        check("rst_ready", in_ready, 0);
        check("rst_rv", result_valid, 0);
        check("rst_data", result_data, 0);
        check("rst_running", running, 0);
        reset_n = 1'b1;

        // MSB mode, single tap of 31
        wr_coefs(31, 0, 0, 0);
        do_start(1'b0);
        smp_d = '{31, 0, 0, 0, 0, 0, 0, 0};
        exp_r = '{13'd960, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
        run_case("t1", 4, 4, 3);

        // LSB mode: alternating ready, low bits recovered
        do_start(1'b1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_ready%0d", k), in_ready, (k % 2 == 0) ? 1 : 0);
            @(negedge clk);
        end
        smp_d = '{31, 0, 0, 0, 0, 0, 0, 0};
        exp_r = '{13'd961, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
        run_case("t2", 2, 2, 4);

        // impulse through {1,2,3,4}
        wr_coefs(1, 2, 3, 4);
        do_start(1'b0);
        smp_d = '{31, 0, 0, 0, 0, 0, 0, 0};
        exp_r = '{13'd0, 13'd32, 13'd64, 13'd96, 13'd0, 13'd0, 13'd0, 13'd0};
        run_case("t3", 5, 5, 3);

        // negative result
        wr_coefs(31, 0, 0, 0);
        do_start(1'b1);
        smp_d = '{-32, 0, 0, 0, 0, 0, 0, 0};
        exp_r = '{13'h1C20, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
        run_case("t4", 1, 1, 4);

        // bubble in the middle produces no result
        wr_coefs(31, 31, 0, 0);
        do_start(1'b1);
        smp_d = '{31, 0, 31, 0, 0, 0, 0, 0};
        smp_v = '{1, 0, 1, 1, 1, 1, 1, 1};
        exp_r = '{13'd961, 13'd961, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
        run_case("t5", 3, 2, 0);
        smp_v = '{default: 1'b1};

        // async reset with a sample in flight
        do_start(1'b1);
        res_q.delete();
        in_valid = 1'b1;
        in_data = 6'sd31;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_io", fir_io_in, 8'h02);
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_rv", result_valid, 0);
        check("t6_rst_running", running, 0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_no_stale", res_q.size(), 0);

        // coef file cleared by reset; new writes wait for the next start
        do_start(1'b0);
        smp_d = '{31, 0, 0, 0, 0, 0, 0, 0};
        exp_r = '{13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
        run_case("t6_cleared", 1, 1, 0);
        wr_coefs(31, 0, 0, 0);
        run_case("t6_pending", 1, 1, 0);

        // start during LOAD is ignored: RUN still arrives 8 cycles after start
        @(negedge clk);
        lsb_mode = 1'b0;
        start = 1'b1;
        st_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_run();
        check("t6_load_start", cyc - st_cyc, 8);
        exp_r = '{13'd960, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
        run_case("t6_newcoef", 1, 1, 3);

        // start in RUN drops an in-flight sample and holds fir_reset for 2 cycles
        res_q.delete();
        in_valid = 1'b1;
        in_data = 6'sd31;
        @(negedge clk);
        in_valid = 1'b0;
        lsb_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_frst1", fir_io_in, 8'h02);
        check("t6_frst_running", running, 0);
        @(negedge clk);
        check("t6_frst2", fir_io_in, 8'h02);
        @(negedge clk);
        check("t6_cfg", fir_io_in, 8'h04);
        wait_run();
        check("t6_dropped", res_q.size(), 0);
        exp_r = '{13'd961, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
        run_case("t6_restart", 1, 1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
